// File: rtl/i2s_tx_pad_ctrl.sv
// i2s_tx_pad_ctrl: I2S master transmitter driving the sck/ws/sd pad group with a 1-entry sample buffer
module i2s_tx_pad_ctrl #(
    parameter int DATA_W   = 16,
    parameter int CLKDIV_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [CLKDIV_W-1:0] clk_div_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    input  logic [DATA_W-1:0]   sample_l_i,
    input  logic [DATA_W-1:0]   sample_r_i,
    output logic                sck_o,
    output logic                ws_o,
    output logic                sd_o,
    output logic                pad_oen_o,
    output logic                underrun_o,
    output logic                busy_o
);
    localparam int FRAME  = 2 * DATA_W;
    localparam int SLOT_W = $clog2(FRAME);
    typedef enum logic [1:0] {IDLE, START, RUN} state_t;
    state_t              state, state_n;
    logic [CLKDIV_W-1:0] div, div_n, cnt, cnt_n;
    logic [SLOT_W-1:0]   slot, slot_n, nxt;
    logic [FRAME-1:0]    shreg, shreg_n, hold, hold_n;
    logic                full, full_n, sck, sck_n, ws, ws_n, oen, oen_n, ur, ur_n;
    logic                tick, fall, last;
    assign tick           = cnt == div;
    assign fall           = tick && sck;
    assign last           = slot == SLOT_W'(FRAME - 1);
    assign nxt            = slot + 1'b1;
    assign sample_ready_o = !full;
    assign busy_o         = state != IDLE;
    assign sck_o          = sck;
    assign ws_o           = ws;
    assign sd_o           = shreg[FRAME-1];
    assign pad_oen_o      = oen;
    assign underrun_o     = ur;
    always_comb begin
        state_n = state;
        div_n   = div;
        cnt_n   = cnt;
        slot_n  = slot;
        shreg_n = shreg;
        hold_n  = hold;
        full_n  = full;
        sck_n   = sck;
        ws_n    = ws;
        oen_n   = oen;
        ur_n    = 1'b0;
        if (sample_valid_i && !full) begin
            hold_n = {sample_l_i, sample_r_i};
            full_n = 1'b1;
        end
        if (state == IDLE) begin
            if (en_i) begin
                state_n = START;
                div_n   = clk_div_i;
                cnt_n   = '0;
                sck_n   = 1'b0;
                ws_n    = 1'b0;
                shreg_n = '0;
                slot_n  = '0;
                oen_n   = 1'b0;
            end
        end else begin
            cnt_n = tick ? '0 : cnt + 1'b1;
            sck_n = tick ? !sck : sck;
            if (fall) begin
                if (state == RUN && last && !en_i) begin
                    state_n = IDLE;
                    ws_n    = 1'b1;
                    shreg_n = '0;
                    slot_n  = '0;
                    oen_n   = 1'b1;
                end else if (state == START || last) begin
                    // frame load; a same-cycle transfer into an empty buffer is kept for the next frame
                    state_n = RUN;
                    slot_n  = '0;
                    ws_n    = 1'b0;
                    shreg_n = full ? hold : '0;
                    ur_n    = !full;
                    full_n  = full ? 1'b0 : full_n;
                end else begin
                    slot_n  = nxt;
                    shreg_n = {shreg[FRAME-2:0], 1'b0};
                    ws_n    = nxt >= SLOT_W'(DATA_W - 1) && nxt <= SLOT_W'(FRAME - 2);
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            div   <= '0;
            cnt   <= '0;
            slot  <= '0;
            shreg <= '0;
            hold  <= '0;
            full  <= 1'b0;
            sck   <= 1'b0;
            ws    <= 1'b1;
            oen   <= 1'b1;
            ur    <= 1'b0;
        end else begin
            state <= state_n;
            div   <= div_n;
            cnt   <= cnt_n;
            slot  <= slot_n;
            shreg <= shreg_n;
            hold  <= hold_n;
            full  <= full_n;
            sck   <= sck_n;
            ws    <= ws_n;
            oen   <= oen_n;
            ur    <= ur_n;
        end
    end
endmodule

// File: tb/tb_i2s_tx_pad_ctrl.sv
// tb_i2s_tx_pad_ctrl: timeline model of the I2S transmitter plus an I2S receiver decoding sd on sck rise
module tb_i2s_tx_pad_ctrl;
    localparam int W = 16;
    localparam int F = 2 * W;
    logic         clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0;
    logic [7:0]   clk_div = '0;
    logic [W-1:0] l = '0, r = '0;
    logic         ready, sck, ws, sd, oen, underrun, busy;
    int           n_chk = 0, n_fail = 0;
    i2s_tx_pad_ctrl #(.DATA_W(W), .CLKDIV_W(8)) dut (
        .clk(clk), .rst(rst), .en_i(en), .clk_div_i(clk_div),
        .sample_valid_i(valid), .sample_ready_o(ready),
        .sample_l_i(l), .sample_r_i(r),
        .sck_o(sck), .ws_o(ws), .sd_o(sd), .pad_oen_o(oen),
        .underrun_o(underrun), .busy_o(busy)
    );
    always #5 clk = !clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: m_t counts clk cycles since START entry (reset to one period at each frame reload)
    logic         m_act = 1'b0, m_full = 1'b0, m_ur = 1'b0;
    int           m_t = 0, m_div = 0;
    logic [F-1:0] m_buf = '0, m_cur = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0;
            m_full = 1'b0;
            m_ur = 1'b0;
            m_t = 0;
        end else begin
            bit xf;
            int p, idx;
            xf = valid && !m_full;
            m_ur = 1'b0;
            if (!m_act) begin
                if (en) begin
                    m_act = 1'b1;
                    m_t = 0;
                    m_div = int'(clk_div);
                end
            end else begin
                m_t++;
                p = 2 * (m_div + 1);
                if (m_t % p == 0) begin
                    idx = m_t / p - 1;
                    if (idx % F == 0) begin
                        if (idx > 0 && !en) m_act = 1'b0;
                        else begin
                            m_cur = m_full ? m_buf : '0;
                            m_ur = !m_full;
                            m_full = 1'b0;
                            m_t = p;
                        end
                    end
                end
            end
            if (xf) begin
                m_buf = {l, r};
                m_full = 1'b1;
            end
        end
    end
    int xf_cnt = 0;
    always @(posedge clk) if (!rst && valid && ready) xf_cnt++;
    logic [W-1:0] rxq[$];
    logic [31:0]  rx = '0;
    logic         prev_sck = 1'b0, prev_ws = 1'b0;
    int           ur_cnt = 0, cyc_n = 0, last_rise = 0, period = 0;
    always @(negedge clk) begin
        logic e_sck, e_ws, e_sd, e_oen;
        int p, idx, k;
        cyc_n++;
        if (!m_act) {e_sck, e_ws, e_sd, e_oen} = 4'b0101;
        else begin
            p = 2 * (m_div + 1);
            e_sck = (m_t % p) >= m_div + 1;
            e_oen = 1'b0;
            if (m_t < p) begin
                e_ws = 1'b0;
                e_sd = 1'b0;
            end else begin
                idx = m_t / p - 1;
                k = idx % F;
                e_ws = k >= W - 1 && k <= 2 * W - 2;
                e_sd = m_cur[F-1-k];
            end
        end
        check("sck", sck, e_sck);
        check("ws", ws, e_ws);
        check("sd", sd, e_sd);
        check("oen", oen, e_oen);
        check("ready", ready, !m_full);
        check("underrun", underrun, m_ur);
        check("busy", busy, m_act);
        if (underrun) ur_cnt++;
        if (rst) begin
            prev_sck = 1'b0;
            prev_ws = 1'b0;
        end else begin
            if (sck && !prev_sck) begin
                rx = {rx[30:0], sd};
                if (ws != prev_ws) rxq.push_back(rx[W-1:0]);
                prev_ws = ws;
                period = cyc_n - last_rise;
                last_rise = cyc_n;
            end
            prev_sck = sck;
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic push(input logic [W-1:0] pl, input logic [W-1:0] pr);
        int b = 0;
        valid = 1'b1;
        l = pl;
        r = pr;
        while (!ready && b < 5000) begin
            step(1);
            b++;
        end
        check("push_timeout", b < 5000, 1'b1);
        step(1);
        valid = 1'b0;
    endtask
    task automatic wait_idle(input int bound);
        int b = 0;
        while (busy && b < bound) begin
            step(1);
            b++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask
    task automatic check_rx(input string name, input logic [W-1:0] exp[$]);
        check({name, "_count"}, rxq.size(), exp.size());
        foreach (exp[i]) if (i < rxq.size()) check(name, rxq[i], exp[i]);
    endtask
    initial begin
        logic [W-1:0] pl[4] = '{16'h1111, 16'h3333, 16'h5555, 16'h7777};
        logic [W-1:0] pr[4] = '{16'h2222, 16'h4444, 16'h6666, 16'h8888};
        step(2);
        check("rst_sck", sck, 1'b0);
        check("rst_ws", ws, 1'b1);
        check("rst_oen", oen, 1'b1);
        check("rst_ready", ready, 1'b1);
        rst = 1'b0;
        step(2);
        // basic frame, div=0, first MSB three edges after en
        push(16'hA5F0, 16'h0F0F);
        check("prefill_ready", ready, 1'b0);
        rxq.delete();
        en = 1'b1;
        step(1);
        check("start_oen", oen, 1'b0);
        check("start_ws", ws, 1'b0);
        step(1);
        check("first_rise_sck", sck, 1'b1);
        check("first_rise_sd", sd, 1'b0);
        step(1);
        check("first_msb", sd, 1'b1);
        step(7);
        en = 1'b0;
        wait_idle(500);
        check_rx("rx_basic", '{16'hA5F0, 16'h0F0F});
        // underrun on second frame
        rxq.delete();
        ur_cnt = 0;
        push(16'h1234, 16'h8765);
        en = 1'b1;
        step(80);
        en = 1'b0;
        wait_idle(500);
        check("underrun_pulses", ur_cnt, 1);
        check_rx("rx_underrun", '{16'h1234, 16'h8765, 16'h0000, 16'h0000});
        // en dropped at slot 5 still completes the frame
        rxq.delete();
        push(16'hC3A5, 16'h5A3C);
        en = 1'b1;
        step(13);
        en = 1'b0;
        wait_idle(500);
        check("end_oen", oen, 1'b1);
        check("end_ws", ws, 1'b1);
        check("end_sck", sck, 1'b0);
        check("end_sd", sd, 1'b0);
        check_rx("rx_drop", '{16'hC3A5, 16'h5A3C});
        // divider latched only at start
        rxq.delete();
        push(16'hBEEF, 16'hCAFE);
        clk_div = 8'd3;
        en = 1'b1;
        step(5);
        clk_div = 8'd1;
        step(55);
        check("period_div3", period, 8);
        en = 1'b0;
        wait_idle(2000);
        check_rx("rx_div3", '{16'hBEEF, 16'hCAFE});
        en = 1'b1;
        step(30);
        check("period_div1", period, 4);
        en = 1'b0;
        wait_idle(2000);
        // streaming: one transfer per frame, four frames
        clk_div = 8'd0;
        rxq.delete();
        ur_cnt = 0;
        xf_cnt = 0;
        push(pl[0], pr[0]);
        en = 1'b1;
        for (int i = 1; i < 4; i++) push(pl[i], pr[i]);
        step(74);
        en = 1'b0;
        wait_idle(500);
        check("stream_xfers", xf_cnt, 4);
        check("stream_underrun", ur_cnt, 0);
        check_rx("rx_stream", '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                16'h5555, 16'h6666, 16'h7777, 16'h8888});
        // async reset mid-frame
        push(16'hFFFF, 16'hFFFF);
        en = 1'b1;
        step(6);
        push(16'hAAAA, 16'hAAAA);
        step(14);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_sck", sck, 1'b0);
        check("arst_ws", ws, 1'b1);
        check("arst_sd", sd, 1'b0);
        check("arst_oen", oen, 1'b1);
        check("arst_ready", ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        en = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
